// File: rtl/sm4_key_expand.sv
// SM4 key schedule: pulls MK0..MK3 from the key store, then expands 32 round keys
// into a register file read by index. Define SM4_DEC_ORDER_EN to add the dec read-order port.
module sm4_key_expand #(
  parameter int KEY_BASE = 0,
  parameter int ADDR_W   = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              key_req,
  output logic [ADDR_W-1:0] key_addr,
  input  logic [31:0]       key_in,
  output logic              busy,
  output logic              done,
  output logic              rk_valid,
`ifdef SM4_DEC_ORDER_EN
  input  logic              dec,
`endif
  input  logic [4:0]        rk_raddr,
  output logic [31:0]       rk_rdata
);

  typedef enum logic [1:0] {IDLE, FETCH, EXPAND, DONE_ST} state_t;

  // S-box packed MSB-first: entry x lives at bits {~x,3'b111} -: 8
  localparam logic [2047:0] SBOX = {
    128'hd690e9fecce13db716b614c228fb2c05,
    128'h2b679a762abe04c3aa44132649860699,
    128'h9c4250f491ef987a33540b43edcfac62,
    128'he4b31ca9c908e89580df94fa758f3fa6,
    128'h4707a7fcf37317ba83593c19e6854fa8,
    128'h686b81b27164da8bf8eb0f4b70569d35,
    128'h1e240e5e6358d1a225227c3b01217887,
    128'hd40046579fd327524c3602e7a0c4c89e,
    128'heabf8ad240c738b5a3f7f2cef96115a1,
    128'he0ae5da49b341a55ad933230f58cb1e3,
    128'h1df6e22e8266ca60c02923ab0d534e6f,
    128'hd5db3745defd8e2f03ff6a726d6c5b51,
    128'h8d1baf92bbddbc7f11d95c411f105ad8,
    128'h0ac13188a5cd7bbd2d74d012b8e5b4b0,
    128'h8969974a0c96777e65b9f109c56ec684,
    128'h18f07dec3adc4d2079ee5f3ed7cb3948
  };

  function automatic logic [7:0] sbox(input logic [7:0] x);
    sbox = SBOX[{~x, 3'b111} -: 8];
  endfunction

  function automatic logic [31:0] t_prime(input logic [31:0] x);
    logic [31:0] b;
    b = '0;
    for (int j = 0; j < 4; j++) b[8*j +: 8] = sbox(x[8*j +: 8]);
    t_prime = b ^ {b[18:0], b[31:19]} ^ {b[8:0], b[31:9]};
  endfunction

  // CK byte j of round i = (4i+j)*7 mod 256, byte 0 in the MSBs
  function automatic logic [31:0] ck_word(input logic [4:0] i);
    logic [9:0] p;
    ck_word = '0;
    for (int j = 0; j < 4; j++) begin
      p = {3'b000, i, 2'(j)} * 10'd7;
      ck_word[31-8*j -: 8] = p[7:0];
    end
  endfunction

  function automatic logic [31:0] fk(input logic [1:0] i);
    case (i)
      2'd0:    fk = 32'hA3B1BAC6;
      2'd1:    fk = 32'h56AA3350;
      2'd2:    fk = 32'h677D9197;
      default: fk = 32'hB27022DC;
    endcase
  endfunction

  state_t                  state_q, state_d;
  logic [4:0]              cnt_q, cnt_d;
  logic [ADDR_W-1:0]       key_addr_q, key_addr_d;
  logic [3:0][31:0]        k_q, k_d;
  logic [31:0][31:0]       rk_q, rk_d;
  logic                    rk_valid_q, rk_valid_d;
  logic [4:0]              cnt_m1;
  logic [31:0]             rk_new;

  assign cnt_m1 = cnt_q - 5'd1;
  assign rk_new = k_q[0] ^ t_prime(k_q[1] ^ k_q[2] ^ k_q[3] ^ ck_word(cnt_q));

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    key_addr_d = key_addr_q;
    k_d        = k_q;
    rk_d       = rk_q;
    rk_valid_d = rk_valid_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d    = FETCH;
          cnt_d      = 5'd0;
          rk_valid_d = 1'b0;
          key_addr_d = ADDR_W'(KEY_BASE);
        end
      end
      FETCH: begin
        // word requested at cnt-1 arrives now
        if (cnt_q != 5'd0) k_d[cnt_m1[1:0]] = key_in ^ fk(cnt_m1[1:0]);
        if (cnt_q < 5'd3) key_addr_d = key_addr_q + ADDR_W'(1);
        if (cnt_q == 5'd4) begin
          state_d = EXPAND;
          cnt_d   = 5'd0;
        end else begin
          cnt_d = cnt_q + 5'd1;
        end
      end
      EXPAND: begin
        rk_d[cnt_q] = rk_new;
        k_d         = {rk_new, k_q[3], k_q[2], k_q[1]};
        if (cnt_q == 5'd31) begin
          state_d    = DONE_ST;
          cnt_d      = 5'd0;
          rk_valid_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 5'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      key_addr_q <= '0;
      k_q        <= '0;
      rk_q       <= '0;
      rk_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      key_addr_q <= key_addr_d;
      k_q        <= k_d;
      rk_q       <= rk_d;
      rk_valid_q <= rk_valid_d;
    end
  end

  assign key_req  = (state_q == FETCH) && (cnt_q != 5'd4);
  assign key_addr = key_addr_q;
  assign busy     = (state_q == FETCH) || (state_q == EXPAND);
  assign done     = (state_q == DONE_ST);
  assign rk_valid = rk_valid_q;

`ifdef SM4_DEC_ORDER_EN
  assign rk_rdata = rk_q[dec ? ~rk_raddr : rk_raddr];
`else
  assign rk_rdata = rk_q[rk_raddr];
`endif

endmodule

// File: tb/tb_sm4_key_expand.sv
// Bench for sm4_key_expand: key-store model, standard SM4 vector, restart/reset corners,
// randomized keys against a word-level reference schedule, and a KEY_BASE=1 instance.
module tb_sm4_key_expand;

  logic        clk, rst, start;
  logic [4:0]  rk_raddr;
  logic        key_req0, key_req1, busy0, busy1, done0, done1, rk_valid0, rk_valid1;
  logic [4:0]  key_addr0, key_addr1;
  logic [31:0] key_in0, key_in1, rk_rdata0, rk_rdata1;
  logic        dec;
  logic [31:0] mem [32];
  int          passes, total;

  typedef struct {
    logic [4:0]  idx;
    logic [31:0] rk;
  } vec_t;
  vec_t tbl [3];

  localparam logic [31:0] FK [4] = '{32'hA3B1BAC6, 32'h56AA3350, 32'h677D9197, 32'hB27022DC};
  localparam logic [7:0] SB [256] = '{
    8'hd6,8'h90,8'he9,8'hfe,8'hcc,8'he1,8'h3d,8'hb7,8'h16,8'hb6,8'h14,8'hc2,8'h28,8'hfb,8'h2c,8'h05,
    8'h2b,8'h67,8'h9a,8'h76,8'h2a,8'hbe,8'h04,8'hc3,8'haa,8'h44,8'h13,8'h26,8'h49,8'h86,8'h06,8'h99,
    8'h9c,8'h42,8'h50,8'hf4,8'h91,8'hef,8'h98,8'h7a,8'h33,8'h54,8'h0b,8'h43,8'hed,8'hcf,8'hac,8'h62,
    8'he4,8'hb3,8'h1c,8'ha9,8'hc9,8'h08,8'he8,8'h95,8'h80,8'hdf,8'h94,8'hfa,8'h75,8'h8f,8'h3f,8'ha6,
    8'h47,8'h07,8'ha7,8'hfc,8'hf3,8'h73,8'h17,8'hba,8'h83,8'h59,8'h3c,8'h19,8'he6,8'h85,8'h4f,8'ha8,
    8'h68,8'h6b,8'h81,8'hb2,8'h71,8'h64,8'hda,8'h8b,8'hf8,8'heb,8'h0f,8'h4b,8'h70,8'h56,8'h9d,8'h35,
    8'h1e,8'h24,8'h0e,8'h5e,8'h63,8'h58,8'hd1,8'ha2,8'h25,8'h22,8'h7c,8'h3b,8'h01,8'h21,8'h78,8'h87,
    8'hd4,8'h00,8'h46,8'h57,8'h9f,8'hd3,8'h27,8'h52,8'h4c,8'h36,8'h02,8'he7,8'ha0,8'hc4,8'hc8,8'h9e,
    8'hea,8'hbf,8'h8a,8'hd2,8'h40,8'hc7,8'h38,8'hb5,8'ha3,8'hf7,8'hf2,8'hce,8'hf9,8'h61,8'h15,8'ha1,
    8'he0,8'hae,8'h5d,8'ha4,8'h9b,8'h34,8'h1a,8'h55,8'had,8'h93,8'h32,8'h30,8'hf5,8'h8c,8'hb1,8'he3,
    8'h1d,8'hf6,8'he2,8'h2e,8'h82,8'h66,8'hca,8'h60,8'hc0,8'h29,8'h23,8'hab,8'h0d,8'h53,8'h4e,8'h6f,
    8'hd5,8'hdb,8'h37,8'h45,8'hde,8'hfd,8'h8e,8'h2f,8'h03,8'hff,8'h6a,8'h72,8'h6d,8'h6c,8'h5b,8'h51,
    8'h8d,8'h1b,8'haf,8'h92,8'hbb,8'hdd,8'hbc,8'h7f,8'h11,8'hd9,8'h5c,8'h41,8'h1f,8'h10,8'h5a,8'hd8,
    8'h0a,8'hc1,8'h31,8'h88,8'ha5,8'hcd,8'h7b,8'hbd,8'h2d,8'h74,8'hd0,8'h12,8'hb8,8'he5,8'hb4,8'hb0,
    8'h89,8'h69,8'h97,8'h4a,8'h0c,8'h96,8'h77,8'h7e,8'h65,8'hb9,8'hf1,8'h09,8'hc5,8'h6e,8'hc6,8'h84,
    8'h18,8'hf0,8'h7d,8'hec,8'h3a,8'hdc,8'h4d,8'h20,8'h79,8'hee,8'h5f,8'h3e,8'hd7,8'hcb,8'h39,8'h48};

  sm4_key_expand #(.KEY_BASE(0), .ADDR_W(5)) u_dut0 (
    .clk(clk), .rst(rst), .start(start), .key_req(key_req0), .key_addr(key_addr0),
    .key_in(key_in0), .busy(busy0), .done(done0), .rk_valid(rk_valid0),
`ifdef SM4_DEC_ORDER_EN
    .dec(dec),
`endif
    .rk_raddr(rk_raddr), .rk_rdata(rk_rdata0));

  sm4_key_expand #(.KEY_BASE(1), .ADDR_W(5)) u_dut1 (
    .clk(clk), .rst(rst), .start(start), .key_req(key_req1), .key_addr(key_addr1),
    .key_in(key_in1), .busy(busy1), .done(done1), .rk_valid(rk_valid1),
`ifdef SM4_DEC_ORDER_EN
    .dec(dec),
`endif
    .rk_raddr(rk_raddr), .rk_rdata(rk_rdata1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // key store: word returned the cycle after the pull
  always @(posedge clk) begin
    if (key_req0) key_in0 <= mem[key_addr0];
    if (key_req1) key_in1 <= mem[key_addr1];
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h, want %h", nm, act, exp);
  endtask

  function automatic logic [31:0] ref_ck(input int i);
    logic [31:0] c;
    c = 0;
    for (int j = 0; j < 4; j++) c = (c << 8) | 32'(((4 * i + j) * 7) % 256);
    return c;
  endfunction

  function automatic logic [31:0] rotl(input logic [31:0] v, input int s);
    return (v << s) | (v >> (32 - s));
  endfunction

  function automatic logic [31:0][31:0] ref_rk(input logic [3:0][31:0] mk);
    logic [31:0] k [36];
    logic [31:0] x, b;
    logic [31:0][31:0] r;
    for (int j = 0; j < 4; j++) k[j] = mk[j] ^ FK[j];
    for (int i = 0; i < 32; i++) begin
      x = k[i+1] ^ k[i+2] ^ k[i+3] ^ ref_ck(i);
      b = {SB[x[31:24]], SB[x[23:16]], SB[x[15:8]], SB[x[7:0]]};
      k[i+4] = k[i] ^ b ^ rotl(b, 13) ^ rotl(b, 23);
      r[i] = k[i+4];
    end
    return r;
  endfunction

  task automatic check_sched(input string tag);
    logic [31:0][31:0] e0, e1;
    e0 = ref_rk({mem[3], mem[2], mem[1], mem[0]});
    e1 = ref_rk({mem[4], mem[3], mem[2], mem[1]});
    for (int i = 0; i < 32; i++) begin
      rk_raddr = 5'(i);
      #1;
      chk($sformatf("%s rk0[%0d]", tag, i), rk_rdata0, e0[i]);
      chk($sformatf("%s rk1[%0d]", tag, i), rk_rdata1, e1[i]);
    end
  endtask

  // mode 0: plain run, 1: extra start while busy, 2: async reset mid-EXPAND
  task automatic run(input int mode);
    int req0, req1, dat0, dat1, dones0;
    logic [19:0] seq0, seq1;
    req0 = 0; req1 = 0; dat0 = 0; dat1 = 0; dones0 = 0; seq0 = '0; seq1 = '0;
    @(negedge clk);
    start = 1'b1;
    for (int n = 1; n <= 45; n++) begin
      @(posedge clk);
      #1;
      if (n == 1) start = 1'b0;
      if (mode == 1 && n == 10) start = 1'b1;
      if (mode == 1 && n == 11) start = 1'b0;
      if (key_req0) begin req0++; seq0 = {seq0[14:0], key_addr0}; end
      if (key_req1) begin req1++; seq1 = {seq1[14:0], key_addr1}; end
      if (done0) begin dones0++; if (dat0 == 0) dat0 = n; end
      if (done1 && dat1 == 0) dat1 = n;
      if (n == 1) chk("busy in fetch", 32'(busy0), 32'd1);
      if (n == 2) chk("rk_valid cleared", 32'(rk_valid0), 32'd0);
      if (mode == 0 && n == 20) begin
        chk("key_addr hold", 32'(key_addr0), 32'd3);
        chk("key_req off in expand", 32'(key_req0), 32'd0);
      end
      if (n == 37) chk("rk_valid before done", 32'(rk_valid0), 32'd0);
      if (n == 38) chk("rk_valid at done", 32'(rk_valid0), 32'd1);
      if (n == 39) begin
        chk("busy after done", 32'(busy0), 32'd0);
        chk("rk_valid held", 32'(rk_valid0), 32'd1);
      end
      if (mode == 2 && n == 20) begin
        #2 rst = 1'b0;
        #1;
        chk("rst busy0", 32'(busy0), 32'd0);
        chk("rst rk_valid0", 32'(rk_valid0), 32'd0);
        chk("rst key_req0", 32'(key_req0), 32'd0);
        chk("rst busy1", 32'(busy1), 32'd0);
        break;
      end
    end
    if (mode == 2) begin
      rk_raddr = 5'd31;
      #1;
      chk("rst rk[31]", rk_rdata0, 32'd0);
      @(negedge clk) rst = 1'b1;
    end else begin
      chk("req count0", 32'(req0), 32'd4);
      chk("addr seq0", 32'(seq0), {12'd0, 5'd0, 5'd1, 5'd2, 5'd3});
      chk("req count1", 32'(req1), 32'd4);
      chk("addr seq1", 32'(seq1), {12'd0, 5'd1, 5'd2, 5'd3, 5'd4});
      chk("done cycle0", 32'(dat0), 32'd38);
      chk("done cycle1", 32'(dat1), 32'd38);
      chk("done pulses", 32'(dones0), 32'd1);
    end
  endtask

  initial begin
    passes = 0; total = 0;
    start = 1'b0; rk_raddr = '0; dec = 1'b0; rst = 1'b1;
    key_in0 = '0; key_in1 = '0;
    tbl[0] = '{5'd0,  32'hF12186F9};
    tbl[1] = '{5'd1,  32'h41662B61};
    tbl[2] = '{5'd31, 32'h9124A012};
    for (int k = 0; k < 32; k++) mem[k] = $urandom();
    mem[0] = 32'h01234567; mem[1] = 32'h89ABCDEF;
    mem[2] = 32'hFEDCBA98; mem[3] = 32'h76543210;

    // async reset mid-cycle
    #3 rst = 1'b0;
    #1;
    chk("reset busy", 32'(busy0), 32'd0);
    chk("reset done", 32'(done0), 32'd0);
    chk("reset key_req", 32'(key_req0), 32'd0);
    chk("reset rk_valid", 32'(rk_valid0), 32'd0);
    chk("reset key_addr", 32'(key_addr0), 32'd0);
    for (int i = 0; i < 32; i++) begin
      rk_raddr = 5'(i);
      #1;
      chk($sformatf("reset rk[%0d]", i), rk_rdata0, 32'd0);
    end
    @(negedge clk) rst = 1'b1;

    run(0);
    for (int v = 0; v < 3; v++) begin
      rk_raddr = tbl[v].idx;
      #1;
      chk($sformatf("std vec rk[%0d]", tbl[v].idx), rk_rdata0, tbl[v].rk);
    end
    check_sched("std");
`ifdef SM4_DEC_ORDER_EN
    dec = 1'b1;
    rk_raddr = 5'd0;  #1; chk("dec rk[0]",  rk_rdata0, 32'h9124A012);
    rk_raddr = 5'd31; #1; chk("dec rk[31]", rk_rdata0, 32'hF12186F9);
    dec = 1'b0;
`endif

    run(1);
    check_sched("restart");

    run(2);
    run(0);
    check_sched("after reset");

    for (int r = 0; r < 4; r++) begin
      for (int k = 0; k < 5; k++) mem[k] = $urandom();
      run(0);
      check_sched($sformatf("rand%0d", r));
    end

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
